alu_cmd_driver: RTL and testbench

Hardware initiator for the ALU's operand/opcode port. It accepts operation commands over a valid/ready stream and buffers them in a small FIFO. Each command is issued to the ALU as a single-cycle `ALU_en` pulse, and the result on `C` is captured after the ALU's fixed latency. The captured result is returned over a valid/ready result stream with a sequence tag. It sits between a command source (CPU-side register block or test sequencer) and the `ALU` instance, and drives every ALU input port.

---
 rtl/alu_cmd_driver.sv | 211 +++++++++++++++++++++
 tb/tb_alu_cmd_driver.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_driver.sv
// ---------------------------------------------------------------------------
// alu_cmd_driver
//
// Purpose: command initiator for an ALU operand/opcode port. Commands come in
// over a valid/ready stream and are queued in a small FIFO. They are issued
// one at a time as a single-cycle ALU_en pulse. The ALU result C is captured
// after ALU_LAT cycles and returned over a valid/ready result stream with a
// 4-bit sequence tag.
//
// Parameters:
//   DATA_W  - operand/result width
//   DEPTH   - command FIFO entries (power of two, >= 2)
//   ALU_LAT - cycles from the ALU_en edge to a valid C (>= 1)
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_a, cmd_b                 operands
//   cmd_a_en, cmd_b_en           A-group / B-group select
//   cmd_a_op, cmd_b_op           A-group / B-group opcodes
//   A, B, ALU_en, a_en, b_en,
//   a_op, b_op                   ALU input drive
//   C                            ALU result
//   res_valid/res_ready          result handshake
//   res_data, res_tag            captured C and sequence tag (mod 16)
//   op_count                     (ALU_DRV_CNT_EN only) saturating issue count
//
// Build option: define ALU_DRV_CNT_EN to add the op_count output.
// ---------------------------------------------------------------------------
module alu_cmd_driver #(
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic              cmd_a_en,
   input  logic              cmd_b_en,
   input  logic [2:0]        cmd_a_op,
   input  logic [1:0]        cmd_b_op,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic              ALU_en,
   output logic              a_en,
   output logic              b_en,
   output logic [2:0]        a_op,
   output logic [1:0]        b_op,
   input  logic [DATA_W-1:0] C,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic [3:0]        res_tag
`ifdef ALU_DRV_CNT_EN
   ,
   output logic [15:0]       op_count
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   typedef struct packed {
      logic [2:0]        a_op;
      logic [1:0]        b_op;
      logic              a_en;
      logic              b_en;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } cmd_t;

   // ---------------- command FIFO ----------------
   cmd_t          mem [DEPTH];
   logic [AW:0]   wr_ptr_reg;
   logic [AW:0]   rd_ptr_reg;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   cmd_t          cmd_word;
   cmd_t          head;

   // Pointers carry an extra MSB: equal low bits with differing MSB means full.
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign empty = (wr_ptr_reg == rd_ptr_reg);

   // Readiness depends only on the registered fill level, so a pop in the
   // same cycle never opens a slot for that cycle's push.
   assign cmd_ready = !rst && !full;
   assign push      = cmd_valid && cmd_ready;

   assign cmd_word = '{a_op: cmd_a_op, b_op: cmd_b_op, a_en: cmd_a_en,
                       b_en: cmd_b_en, a: cmd_a, b: cmd_b};
   assign head     = mem[rd_ptr_reg[AW-1:0]];

   // Storage has no reset; only the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg[AW-1:0]] <= cmd_word;
      end
   end

   // ---------------- issue FSM ----------------
   logic [1:0]        state_reg;
   logic [CW-1:0]     cnt_reg;
   logic [DATA_W-1:0] a_reg;
   logic [DATA_W-1:0] b_reg;
   logic              a_en_reg;
   logic              b_en_reg;
   logic [2:0]        a_op_reg;
   logic [1:0]        b_op_reg;
   logic [DATA_W-1:0] res_data_reg;
   logic [3:0]        tag_reg;

   assign pop = (state_reg == ST_IDLE) && !empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         state_reg    <= ST_IDLE;
         cnt_reg      <= '0;
         a_reg        <= '0;
         b_reg        <= '0;
         a_en_reg     <= 1'b0;
         b_en_reg     <= 1'b0;
         a_op_reg     <= '0;
         b_op_reg     <= '0;
         res_data_reg <= '0;
         tag_reg      <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
         end

         case (state_reg)
            ST_IDLE: begin
               if (pop) begin
                  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
                  a_reg      <= head.a;
                  b_reg      <= head.b;
                  a_en_reg   <= head.a_en;
                  b_en_reg   <= head.b_en;
                  a_op_reg   <= head.a_op;
                  b_op_reg   <= head.b_op;
                  state_reg  <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               cnt_reg   <= CW'(ALU_LAT);
               state_reg <= ST_WAIT;
            end
            ST_WAIT: begin
               // The counter sits at 1 in the last WAIT cycle; C is valid
               // at the edge that ends it.
               if (cnt_reg == CW'(1)) begin
                  res_data_reg <= C;
                  a_en_reg     <= 1'b0;
                  b_en_reg     <= 1'b0;
                  state_reg    <= ST_RESP;
               end else begin
                  cnt_reg <= cnt_reg - CW'(1);
               end
            end
            default: begin // ST_RESP
               if (res_ready) begin
                  tag_reg   <= tag_reg + 4'd1;
                  state_reg <= ST_IDLE;
               end
            end
         endcase
      end
   end

   // Operands and opcodes stay at their last issued values so the ALU never
   // sees them move while it is computing.
   assign A         = a_reg;
   assign B         = b_reg;
   assign a_en      = a_en_reg;
   assign b_en      = b_en_reg;
   assign a_op      = a_op_reg;
   assign b_op      = b_op_reg;
   assign ALU_en    = (state_reg == ST_ISSUE);
   assign res_valid = (state_reg == ST_RESP);
   assign res_data  = res_data_reg;
   assign res_tag   = tag_reg;

`ifdef ALU_DRV_CNT_EN
   logic [15:0] op_count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_count_reg <= '0;
      end else if ((state_reg == ST_ISSUE) && (op_count_reg != 16'hFFFF)) begin
         op_count_reg <= op_count_reg + 16'd1;
      end
   end

   assign op_count = op_count_reg;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_driver
//
// Drives alu_cmd_driver with a simple registered ALU model. Two instances:
// u_dut with ALU_LAT=1 (main tests) and u_dut3 with ALU_LAT=3 (long wait).
// Results of u_dut are checked by a scoreboard queue filled at command
// acceptance and drained by a monitor at each result handshake.
// ---------------------------------------------------------------------------
module tb_alu_cmd_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // ---------------- u_dut (ALU_LAT = 1) ----------------
   logic       cmd_valid, cmd_ready, cmd_a_en, cmd_b_en;
   logic [7:0] cmd_a, cmd_b;
   logic [2:0] cmd_a_op;
   logic [1:0] cmd_b_op;
   logic [7:0] A, B, C;
   logic       ALU_en, a_en, b_en;
   logic [2:0] a_op;
   logic [1:0] b_op;
   logic       res_valid, res_ready;
   logic [7:0] res_data;
   logic [3:0] res_tag;
`ifdef ALU_DRV_CNT_EN
   logic [15:0] op_count;
   logic [15:0] op_count_3;
`endif

   // ---------------- u_dut3 (ALU_LAT = 3) ----------------
   logic       cmd_valid_3, cmd_ready_3, cmd_a_en_3, cmd_b_en_3;
   logic [7:0] cmd_a_3, cmd_b_3;
   logic [2:0] cmd_a_op_3;
   logic [1:0] cmd_b_op_3;
   logic [7:0] A_3, B_3, C_3;
   logic       ALU_en_3, a_en_3, b_en_3;
   logic [2:0] a_op_3;
   logic [1:0] b_op_3;
   logic       res_valid_3, res_ready_3;
   logic [7:0] res_data_3;
   logic [3:0] res_tag_3;

   alu_cmd_driver #(.DATA_W(8), .DEPTH(4), .ALU_LAT(1)) u_dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .cmd_a_en(cmd_a_en), .cmd_b_en(cmd_b_en),
      .cmd_a_op(cmd_a_op), .cmd_b_op(cmd_b_op),
      .A(A), .B(B), .ALU_en(ALU_en), .a_en(a_en), .b_en(b_en),
      .a_op(a_op), .b_op(b_op), .C(C),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_tag(res_tag)
`ifdef ALU_DRV_CNT_EN
      , .op_count(op_count)
`endif
   );

   alu_cmd_driver #(.DATA_W(8), .DEPTH(4), .ALU_LAT(3)) u_dut3 (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid_3), .cmd_ready(cmd_ready_3),
      .cmd_a(cmd_a_3), .cmd_b(cmd_b_3),
      .cmd_a_en(cmd_a_en_3), .cmd_b_en(cmd_b_en_3),
      .cmd_a_op(cmd_a_op_3), .cmd_b_op(cmd_b_op_3),
      .A(A_3), .B(B_3), .ALU_en(ALU_en_3), .a_en(a_en_3), .b_en(b_en_3),
      .a_op(a_op_3), .b_op(b_op_3), .C(C_3),
      .res_valid(res_valid_3), .res_ready(res_ready_3),
      .res_data(res_data_3), .res_tag(res_tag_3)
`ifdef ALU_DRV_CNT_EN
      , .op_count(op_count_3)
`endif
   );

   // ---------------- ALU model ----------------
   function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic ae, input logic be,
                                         input logic [2:0] aop, input logic [1:0] bop);
      logic [7:0] r;
      r = 8'h00;
      if (ae) begin
         case (aop)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: r = a << 1;
            default: r = a >> 1;
         endcase
      end else if (be) begin
         case (bop)
            2'd0: r = ~(a & b);
            2'd1: r = ~(a | b);
            2'd2: r = ~(a ^ b);
            default: r = b;
         endcase
      end
      return r;
   endfunction

   logic [7:0] c1, p0, p1, p2;
   always @(posedge clk) begin
      if (rst) c1 <= 8'h00;
      else if (ALU_en) c1 <= alu_fn(A, B, a_en, b_en, a_op, b_op);
   end
   assign C = c1;

   always @(posedge clk) begin
      if (rst) begin
         p0 <= 8'h00; p1 <= 8'h00; p2 <= 8'h00;
      end else begin
         if (ALU_en_3) p0 <= alu_fn(A_3, B_3, a_en_3, b_en_3, a_op_3, b_op_3);
         p1 <= p0;
         p2 <= p1;
      end
   end
   assign C_3 = p2;

   // ---------------- checking infrastructure ----------------
   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       ae;
      logic       be;
      logic [2:0] aop;
      logic [1:0] bop;
      logic [7:0] res;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic [3:0] tag;
   } exp_t;

   vec_t tbl [17];
   exp_t sb_q [$];
   logic [3:0] exp_tag;
   int n_vec  = 0;
   int n_fail = 0;
   int alu_en_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Result monitor: a handshake seen at this negedge completes at the next posedge.
   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst && res_valid && res_ready) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_result: got data %h tag %0d, required no result", res_data, res_tag);
         end else begin
            e = sb_q.pop_front();
            $display("result tag=%0d data=%h (expected tag=%0d data=%h)", res_tag, res_data, e.tag, e.data);
            chk("res_data", 32'(res_data), 32'(e.data));
            chk("res_tag", 32'(res_tag), 32'(e.tag));
         end
      end
   end

   always @(negedge clk) begin
      if (rst) alu_en_cnt <= 0;
      else if (ALU_en) alu_en_cnt <= alu_en_cnt + 1;
   end

   task automatic drive(input vec_t v);
      cmd_a    = v.a;
      cmd_b    = v.b;
      cmd_a_en = v.ae;
      cmd_b_en = v.be;
      cmd_a_op = v.aop;
      cmd_b_op = v.bop;
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic push_cmd(input vec_t v, output bit stalled);
      int   guard;
      logic ok;
      guard   = 0;
      stalled = 1'b0;
      drive(v);
      cmd_valid = 1'b1;
      @(negedge clk);
      while (!cmd_ready && guard < 400) begin
         stalled = 1'b1;
         guard++;
         @(negedge clk);
      end
      ok = cmd_ready;
      if (!ok) begin
         n_vec++;
         n_fail++;
         $display("FAIL push_timeout: got cmd_ready 0, required 1");
      end
      @(posedge clk);
      if (ok) begin
         sb_q.push_back('{data: v.res, tag: exp_tag});
         $display("push a=%h b=%h a_en=%0d b_en=%0d a_op=%0d b_op=%0d tag=%0d",
                  v.a, v.b, v.ae, v.be, v.aop, v.bop, exp_tag);
         exp_tag = exp_tag + 4'd1;
      end
      #1 cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (sb_q.size() != 0 && g < 300) begin
         @(posedge clk);
         g++;
      end
      n_vec++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: got %0d results outstanding, required 0", sb_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string t);
      chk({t, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
      chk({t, "_ALU_en"},    32'(ALU_en),    32'd0);
      chk({t, "_a_en"},      32'(a_en),      32'd0);
      chk({t, "_b_en"},      32'(b_en),      32'd0);
      chk({t, "_A"},         32'(A),         32'd0);
      chk({t, "_B"},         32'(B),         32'd0);
      chk({t, "_a_op"},      32'(a_op),      32'd0);
      chk({t, "_b_op"},      32'(b_op),      32'd0);
      chk({t, "_res_valid"}, 32'(res_valid), 32'd0);
      chk({t, "_res_data"},  32'(res_data),  32'd0);
      chk({t, "_res_tag"},   32'(res_tag),   32'd0);
`ifdef ALU_DRV_CNT_EN
      chk({t, "_op_count"},  32'(op_count),  32'd0);
`endif
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit st;
      int hi_cnt;

      //          a      b      ae    be    aop   bop   result
      tbl[0]  = '{8'h05, 8'h03, 1'b1, 1'b0, 3'd0, 2'd0, 8'h08};
      tbl[1]  = '{8'h10, 8'h03, 1'b1, 1'b0, 3'd1, 2'd0, 8'h0D};
      tbl[2]  = '{8'hF0, 8'h3C, 1'b1, 1'b0, 3'd2, 2'd0, 8'h30};
      tbl[3]  = '{8'hF0, 8'h0C, 1'b1, 1'b0, 3'd3, 2'd0, 8'hFC};
      tbl[4]  = '{8'hAA, 8'hFF, 1'b1, 1'b0, 3'd4, 2'd0, 8'h55};
      tbl[5]  = '{8'h0F, 8'h00, 1'b1, 1'b0, 3'd5, 2'd0, 8'hF0};
      tbl[6]  = '{8'h81, 8'h00, 1'b1, 1'b0, 3'd6, 2'd0, 8'h02};
      tbl[7]  = '{8'h81, 8'h00, 1'b1, 1'b0, 3'd7, 2'd0, 8'h40};
      tbl[8]  = '{8'hF0, 8'h3C, 1'b0, 1'b1, 3'd0, 2'd0, 8'hCF};
      tbl[9]  = '{8'hF0, 8'h0C, 1'b0, 1'b1, 3'd0, 2'd1, 8'h03};
      tbl[10] = '{8'hAA, 8'hFF, 1'b0, 1'b1, 3'd0, 2'd2, 8'hAA};
      tbl[11] = '{8'h12, 8'h34, 1'b0, 1'b1, 3'd0, 2'd3, 8'h34};
      tbl[12] = '{8'h01, 8'h02, 1'b1, 1'b1, 3'd0, 2'd3, 8'h03};
      tbl[13] = '{8'h55, 8'h66, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00};
      tbl[14] = '{8'h00, 8'h01, 1'b1, 1'b0, 3'd1, 2'd0, 8'hFF};
      tbl[15] = '{8'hFF, 8'h01, 1'b1, 1'b0, 3'd0, 2'd0, 8'h00};
      tbl[16] = '{8'h7F, 8'h7F, 1'b1, 1'b0, 3'd0, 2'd0, 8'hFE};

      rst = 1'b1;
      exp_tag = 4'd0;
      cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_a_en = 1'b0; cmd_b_en = 1'b0;
      cmd_a_op = '0; cmd_b_op = '0; res_ready = 1'b0;
      cmd_valid_3 = 1'b0; cmd_a_3 = '0; cmd_b_3 = '0; cmd_a_en_3 = 1'b0; cmd_b_en_3 = 1'b0;
      cmd_a_op_3 = '0; cmd_b_op_3 = '0; res_ready_3 = 1'b0;

      // --- reset values ---
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      chk("reset_cmd_ready_3", 32'(cmd_ready_3), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_release_cmd_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1;

      // --- single command: exact latency ---
      res_ready = 1'b1;
      drive(tbl[0]);
      cmd_valid = 1'b1;
      @(posedge clk);                              // E0
      sb_q.push_back('{data: tbl[0].res, tag: exp_tag});
      exp_tag = exp_tag + 4'd1;
      #1 cmd_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);                           // cycle after E0+k
         chk($sformatf("single_ALU_en_c%0d", k), 32'(ALU_en), 32'(k == 1));
         chk($sformatf("single_res_valid_c%0d", k), 32'(res_valid), 32'(k == 3));
         if (k == 1) begin
            chk("single_A", 32'(A), 32'h05);
            chk("single_B", 32'(B), 32'h03);
            chk("single_a_en", 32'(a_en), 32'd1);
            chk("single_b_en", 32'(b_en), 32'd0);
            chk("single_a_op", 32'(a_op), 32'd0);
         end
         if (k == 2) chk("single_a_en_wait", 32'(a_en), 32'd1);
         if (k == 3) chk("single_a_en_resp", 32'(a_en), 32'd0);
      end
      @(posedge clk);
      #1;

      // --- backpressure: fill FIFO, hold RESP ---
      res_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         push_cmd(tbl[i], st);
         chk($sformatf("bp_push%0d_no_stall", i), 32'(st), 32'd0);
      end
      drive(tbl[6]);
      cmd_valid = 1'b1;
      @(negedge clk);
      chk("bp_sixth_cmd_ready", 32'(cmd_ready), 32'd0);
      for (int k = 0; k < 10; k++) begin
         chk("hold_res_valid", 32'(res_valid), 32'd1);
         chk("hold_res_data", 32'(res_data), 32'(tbl[1].res));
         chk("hold_res_tag", 32'(res_tag), 32'd1);
         chk("hold_ALU_en", 32'(ALU_en), 32'd0);
         chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      res_ready = 1'b1;
      push_cmd(tbl[6], st);
      drain();

      // --- reset during WAIT with two commands queued ---
      push_cmd(tbl[7], st);
      push_cmd(tbl[8], st);
      push_cmd(tbl[9], st);
      rst = 1'b1;                                  // first op is in WAIT now
      #1;
      chk_all_zero("midrst");
      sb_q.delete();
      exp_tag = 4'd0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      hi_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (res_valid || ALU_en) hi_cnt++;
      end
      chk("midrst_no_activity", 32'(hi_cnt), 32'd0);
      chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1;

      // --- table run: 17 ops, tags 0..15 then 0 ---
      for (int i = 0; i < 17; i++) begin
         push_cmd(tbl[i], st);
      end
      drain();
      chk("table_issue_count", 32'(alu_en_cnt), 32'd17);
`ifdef ALU_DRV_CNT_EN
      chk("table_op_count", 32'(op_count), 32'd17);
`endif

      // --- ALU_LAT = 3 instance ---
      cmd_a_3 = tbl[1].a; cmd_b_3 = tbl[1].b; cmd_a_en_3 = tbl[1].ae;
      cmd_b_en_3 = tbl[1].be; cmd_a_op_3 = tbl[1].aop; cmd_b_op_3 = tbl[1].bop;
      cmd_valid_3 = 1'b1;
      @(posedge clk);                              // E0
      #1 cmd_valid_3 = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk($sformatf("lat3_ALU_en_c%0d", k), 32'(ALU_en_3), 32'(k == 1));
         chk($sformatf("lat3_res_valid_c%0d", k), 32'(res_valid_3), 32'(k == 5));
         if (k >= 2 && k <= 4) begin
            chk("lat3_wait_A", 32'(A_3), 32'(tbl[1].a));
            chk("lat3_wait_B", 32'(B_3), 32'(tbl[1].b));
            chk("lat3_wait_a_op", 32'(a_op_3), 32'(tbl[1].aop));
            chk("lat3_wait_a_en", 32'(a_en_3), 32'd1);
         end
         if (k == 5) begin
            chk("lat3_res_data", 32'(res_data_3), 32'(tbl[1].res));
            chk("lat3_res_tag", 32'(res_tag_3), 32'd0);
         end
      end
      $display("lat3 result tag=%0d data=%h", res_tag_3, res_data_3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion by 100000 ns, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
